bound_flasher_multi: RTL and testbench
======================================

// Module: bound_flasher_multi
// PURPOSE
//  Parametrised next-generation bound flasher. Drives an N_LED-wide thermometer LED bar through
//  the fixed phase sequence UP1 -> DN1 -> UP2 -> DN2 -> IDLE, one LED per step tick.
//  FLICK starts a sequence and kicks DN phases back to UP1 at programmable kick points.
//  Adds over the previous fixed 16-LED flasher: generic width, bounds and kick points,
//  a step prescaler, BUSY/PHASE status outputs, and an optional mirrored fill direction.
// PARAMETERS
//  N_LED    16  number of LEDs (>=4); cnt range 0..N_LED
//  LO1      5   DN1 lower bound; 0 < LO1 < HI2
//  HI2      10  UP2 upper bound; LO1 < HI2 < N_LED
//  KICK_A   5   kick point checked in DN1/DN2; 0 <= KICK_A < N_LED
//  KICK_B   0   second kick point, same rules as KICK_A
//  STEP_DIV 1   clocks per step tick (>=1); 1 = one LED per clock
// PORTS
//  CLK    in   1      rising-edge clock
//  RST    in   1      asynchronous reset, active-high
//  FLICK  in   1      start/kickback request, level-sampled on CLK
//  MIRROR in   1      fill from LED[N_LED-1] down (only with BOUND_FLASHER_MIRROR_EN)
//  LED    out  N_LED  thermometer: lowest cnt bits lit (LED = (1<<cnt)-1)
//  BUSY   out  1      1 when state != IDLE
//  PHASE  out  3      0 IDLE, 1 UP1, 2 DN1, 3 UP2, 4 DN2
// BEHAVIOUR
//  - RST=1 (async): state IDLE, cnt 0, tick counter 0, LED 0, BUSY 0, PHASE 0, mirror latch 0.
//    Reset mid-sequence aborts immediately; FLICK is ignored while RST=1.
//  - cnt width $clog2(N_LED+1); tick counter width $clog2(STEP_DIV) (min 1); tick fires when the
//    counter equals STEP_DIV-1, then wraps to 0. Counter held at 0 in IDLE.
//  - IDLE: FLICK checked on every clock. FLICK=1 -> state UP1, cnt stays 0, tick counter restarts.
//    First LED lights STEP_DIV clocks after the accepting edge.
//  - All state/cnt updates below happen only on tick edges:
//    UP1: cnt<N_LED -> cnt+1; cnt==N_LED -> DN1, cnt<=N_LED-1 (peak held one tick).
//    DN1: cnt==KICK_A or KICK_B with FLICK=1 -> UP1, cnt<=cnt+1 (kickback; takes priority);
//         else cnt>LO1 -> cnt-1; cnt==LO1 -> UP2, cnt<=LO1+1.
//    UP2: cnt<HI2 -> cnt+1; cnt==HI2 -> DN2, cnt<=HI2-1.
//    DN2: kickback rule as DN1; else cnt>0 -> cnt-1; cnt==0 -> IDLE, cnt stays 0.
//    A DN2 kickback at cnt==0 (KICK_B=0 default) restarts UP1 with cnt<=1.
//  - FLICK during UP1/UP2, or in DN phases away from kick points, is ignored.
//  - FLICK is level-sampled at the tick edge; a pulse not overlapping that edge is missed.
//  - LED, BUSY and PHASE are registered; LED is decoded from registered cnt (no combinational
//    path from FLICK). Full sequence with defaults and no kicks = 43 clocks, accepting edge to IDLE.
// CONFIGURATION
//  BOUND_FLASHER_MIRROR_EN defined: MIRROR port exists and is latched on the IDLE->UP1 edge.
//    Latched 1 -> LED bit-reversed (LED[N_LED-1] lights first). MIRROR changes mid-sequence are
//    ignored until the next start.
//  Not defined: no MIRROR port; LED[0] always lights first.
// TESTING
//  1 normal: defaults, 1-clock FLICK in IDLE -> cnt 1..16, 15..5, 6..10, 9..0;
//    BUSY falls 43 clocks after start; LED=16'h001F at the DN1->UP2 turn.
//  2 kick at KICK_A: FLICK held high at the DN1 tick where cnt==5 -> PHASE 1, LED=16'h003F next tick.
//  3 kick at 0: FLICK at the DN2 tick where cnt==0 -> UP1 with cnt=1, no IDLE gap, BUSY stays 1.
//  4 ignored flicks: 1-clock FLICK pulses every 2 clocks during UP1/UP2 and DN1 cnt 14..6
//    -> sequence identical to test 1.
//  5 reset mid-DN2 (cnt=7) -> LED=0, PHASE=0, BUSY=0 asynchronously; FLICK with RST=1 ignored;
//    first FLICK after release -> LED=16'h0001 one clock later.
//  6 N_LED=8, LO1=2, HI2=5, KICK_A=2, STEP_DIV=3, MIRROR=1 (macro on)
//    -> LED 8'h80 three clocks after start, each step 3 clocks apart.

Source files
------------

// File: rtl/bound_flasher_multi.sv
// bound_flasher_multi: parametrised thermometer bound flasher (UP1/DN1/UP2/DN2).
// Optional mirrored fill direction enabled by defining BOUND_FLASHER_MIRROR_EN.
module bound_flasher_multi #(
  parameter int N_LED    = 16,
  parameter int LO1      = 5,
  parameter int HI2      = 10,
  parameter int KICK_A   = 5,
  parameter int KICK_B   = 0,
  parameter int STEP_DIV = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLICK,
`ifdef BOUND_FLASHER_MIRROR_EN
  input  logic             MIRROR,
`endif
  output logic [N_LED-1:0] LED,
  output logic             BUSY,
  output logic [2:0]       PHASE
);

  localparam int CW = $clog2(N_LED + 1);
  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [CW-1:0] C_N  = CW'(N_LED);
  localparam logic [CW-1:0] C_LO = CW'(LO1);
  localparam logic [CW-1:0] C_HI = CW'(HI2);
  localparam logic [CW-1:0] C_KA = CW'(KICK_A);
  localparam logic [CW-1:0] C_KB = CW'(KICK_B);
  localparam logic [TW-1:0] T_LAST = TW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP1  = 3'd1,
    S_DN1  = 3'd2,
    S_UP2  = 3'd3,
    S_DN2  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_LED-1:0] therm;
  logic            busy_q;
  logic [2:0]      phase_q;
  logic            tick;
  logic            kick;

`ifdef BOUND_FLASHER_MIRROR_EN
  logic            mirror_q, mirror_d;
`endif

  assign tick = (tick_q == T_LAST);
  assign kick = FLICK && ((cnt_q == C_KA) || (cnt_q == C_KB));

  // Next state, LED count and step prescaler.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = '0;
    if (state_q != S_IDLE) begin
      tick_d = tick ? '0 : tick_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (FLICK) begin
          state_d = S_UP1;
          cnt_d   = '0;
        end
      end
      S_UP1: begin
        if (tick) begin
          if (cnt_q == C_N) begin
            state_d = S_DN1;
            cnt_d   = C_N - 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DN1: begin
        if (tick) begin
          if (kick) begin
            state_d = S_UP1;
            cnt_d   = cnt_q + 1'b1;
          end else if (cnt_q > C_LO) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = S_UP2;
            cnt_d   = C_LO + 1'b1;
          end
        end
      end
      S_UP2: begin
        if (tick) begin
          if (cnt_q == C_HI) begin
            state_d = S_DN2;
            cnt_d   = C_HI - 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DN2: begin
        if (tick) begin
          if (kick) begin
            state_d = S_UP1;
            cnt_d   = cnt_q + 1'b1;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BOUND_FLASHER_MIRROR_EN
  // Fill direction is captured only when a sequence starts.
  always_comb begin
    mirror_d = mirror_q;
    if ((state_q == S_IDLE) && FLICK) begin
      mirror_d = MIRROR;
    end
  end
`endif

  // Thermometer decode of the next count, optionally bit-reversed.
  always_comb begin
    therm = '0;
    led_d = '0;
    for (int i = 0; i < N_LED; i++) begin
      therm[i] = (CW'(i) < cnt_d);
    end
    for (int i = 0; i < N_LED; i++) begin
`ifdef BOUND_FLASHER_MIRROR_EN
      led_d[i] = mirror_d ? therm[N_LED-1-i] : therm[i];
`else
      led_d[i] = therm[i];
`endif
    end
  end

  // State, count, prescaler and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tick_q   <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      phase_q  <= 3'd0;
`ifdef BOUND_FLASHER_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      led_q    <= led_d;
      busy_q   <= (state_d != S_IDLE);
      phase_q  <= state_d;
`ifdef BOUND_FLASHER_MIRROR_EN
      mirror_q <= mirror_d;
`endif
    end
  end

  assign LED   = led_q;
  assign BUSY  = busy_q;
  assign PHASE = phase_q;

endmodule

// File: tb/tb_bound_flasher_multi.sv
// tb_bound_flasher_multi: two flasher instances against a table-walking model.
// Mirror expectations follow BOUND_FLASHER_MIRROR_EN.
module tb_bound_flasher_multi;

`ifdef BOUND_FLASHER_MIRROR_EN
  localparam bit MIR_EN = 1'b1;
`else
  localparam bit MIR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        flick;
  logic        mirror;
  logic [15:0] led0;
  logic        busy0;
  logic [2:0]  ph0;
  logic [7:0]  led1;
  logic        busy1;
  logic [2:0]  ph1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  bound_flasher_multi u0 (
    .CLK   (CLK),
    .RST   (RST),
    .FLICK (flick),
`ifdef BOUND_FLASHER_MIRROR_EN
    .MIRROR(mirror),
`endif
    .LED   (led0),
    .BUSY  (busy0),
    .PHASE (ph0)
  );

  bound_flasher_multi #(
    .N_LED(8), .LO1(2), .HI2(5),
    .KICK_A(2), .KICK_B(0), .STEP_DIV(3)
  ) u1 (
    .CLK   (CLK),
    .RST   (RST),
    .FLICK (flick),
`ifdef BOUND_FLASHER_MIRROR_EN
    .MIRROR(mirror),
`endif
    .LED   (led1),
    .BUSY  (busy1),
    .PHASE (ph1)
  );

  // Model: each unit walks a precomputed table of (phase, cnt) steps.
  int p_n[2], p_lo[2], p_hi[2], p_ka[2], p_kb[2], p_div[2];
  int sph[2][64];
  int scnt[2][64];
  int slen[2];
  int m_idx[2];
  int m_clk[2];
  bit m_mir[2];

  task automatic chk(string tag, logic [31:0] obs, int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic add(int u, int ph, int c);
    sph[u][slen[u]]  = ph;
    scnt[u][slen[u]] = c;
    slen[u]++;
  endtask

  task automatic build(int u);
    slen[u] = 0;
    add(u, 1, 0);
    for (int k = 1; k <= p_n[u]; k++) add(u, 1, k);
    for (int k = p_n[u] - 1; k >= p_lo[u]; k--) add(u, 2, k);
    for (int k = p_lo[u] + 1; k <= p_hi[u]; k++) add(u, 3, k);
    for (int k = p_hi[u] - 1; k >= 0; k--) add(u, 4, k);
  endtask

  function automatic int m_ph(int u);
    return (m_idx[u] < 0) ? 0 : sph[u][m_idx[u]];
  endfunction

  function automatic int m_cnt(int u);
    return (m_idx[u] < 0) ? 0 : scnt[u][m_idx[u]];
  endfunction

  function automatic int unsigned e_led(int u);
    longint t;
    int unsigned r;
    t = (64'd1 << m_cnt(u)) - 1;
    if (MIR_EN && m_mir[u]) begin
      r = 0;
      for (int i = 0; i < p_n[u]; i++)
        if (t[i]) r = r | (32'd1 << (p_n[u] - 1 - i));
      return r;
    end
    return int'(t);
  endfunction

  task automatic m_reset();
    for (int u = 0; u < 2; u++) begin
      m_idx[u] = -1;
      m_clk[u] = 0;
      m_mir[u] = 1'b0;
    end
  endtask

  task automatic m_step(int u, bit f, bit mir);
    int ph, c;
    if (m_idx[u] < 0) begin
      if (f) begin
        m_idx[u] = 0;
        m_clk[u] = 0;
        m_mir[u] = mir;
      end
    end else begin
      m_clk[u]++;
      if (m_clk[u] == p_div[u]) begin
        m_clk[u] = 0;
        ph = sph[u][m_idx[u]];
        c  = scnt[u][m_idx[u]];
        if ((ph == 2 || ph == 4) && f && (c == p_ka[u] || c == p_kb[u])) begin
          m_idx[u] = c + 1;
        end else begin
          m_idx[u]++;
          if (m_idx[u] == slen[u]) m_idx[u] = -1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("led0", {16'd0, led0}, e_led(0));
    chk("ph0", {29'd0, ph0}, m_ph(0));
    chk("busy0", {31'd0, busy0}, (m_idx[0] >= 0));
    chk("led1", {24'd0, led1}, e_led(1));
    chk("ph1", {29'd0, ph1}, m_ph(1));
    chk("busy1", {31'd0, busy1}, (m_idx[1] >= 0));
  endtask

  task automatic cycle();
    m_step(0, flick, mirror);
    m_step(1, flick, mirror);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic start();
    flick = 1'b1;
    cycle();
    flick = 1'b0;
  endtask

  task automatic wait_m0(int ph, int c);
    int k;
    k = 0;
    while (!(m_ph(0) == ph && m_cnt(0) == c) && k < 200) begin
      cycle();
      k++;
    end
    chk("wait_reach", {31'd0, (k < 200)}, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((m_idx[0] >= 0 || m_idx[1] >= 0) && k < 300) begin
      cycle();
      k++;
    end
    chk("wait_idle", {31'd0, (k < 300)}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, ph, c;
    bit got1, seen;
    logic [7:0] v1, v6;
    logic [15:0] pled;
    logic [2:0] pph;

    p_n   = '{16, 8};
    p_lo  = '{5, 2};
    p_hi  = '{10, 5};
    p_ka  = '{5, 2};
    p_kb  = '{0, 0};
    p_div = '{1, 3};
    build(0);
    build(1);
    m_reset();

    RST = 1'b1;
    flick = 1'b0;
    mirror = 1'b0;
    #2;
    chk("rst_led0", {16'd0, led0}, 0);
    chk("rst_ph0", {29'd0, ph0}, 0);
    chk("rst_busy0", {31'd0, busy0}, 0);
    compare_all();
    @(negedge CLK);
    RST = 1'b0;

    // Normal sequence plus scaled/mirrored second unit.
    mirror = 1'b1;
    start();
    mirror = 1'b0;
    n = 0; got1 = 0; n1 = 0; v1 = 0; v6 = 0; seen = 0;
    pled = led0; pph = ph0;
    while (busy0 && n < 100) begin
      cycle();
      n++;
      if (!got1 && led1 != 0) begin
        got1 = 1; n1 = n; v1 = led1;
      end
      if (n == 6) v6 = led1;
      if (ph0 == 3'd3 && pph == 3'd2) begin
        seen = 1;
        chk("turn_led", {16'd0, pled}, 32'h1F);
      end
      pled = led0; pph = ph0;
    end
    chk("busy_len", n, 43);
    chk("turn_seen", {31'd0, seen}, 1);
    chk("u1_first_n", n1, 3);
    chk("u1_first_led", {24'd0, v1}, MIR_EN ? 32'h80 : 32'h01);
    chk("u1_step2_led", {24'd0, v6}, MIR_EN ? 32'hC0 : 32'h03);
    wait_idle();

    // Kickback at KICK_A in DN1.
    start();
    wait_m0(2, 5);
    flick = 1'b1;
    cycle();
    flick = 1'b0;
    chk("kickA_ph", {29'd0, ph0}, 1);
    chk("kickA_led", {16'd0, led0}, 32'h3F);
    wait_idle();

    // Kickback at cnt 0 in DN2.
    start();
    wait_m0(4, 0);
    flick = 1'b1;
    cycle();
    flick = 1'b0;
    chk("kick0_ph", {29'd0, ph0}, 1);
    chk("kick0_led", {16'd0, led0}, 32'h1);
    chk("kick0_busy", {31'd0, busy0}, 1);
    wait_idle();

    // Flicks away from kick points are ignored.
    start();
    n = 0;
    while (busy0 && n < 100) begin
      ph = m_ph(0);
      c = m_cnt(0);
      flick = (n % 2 == 1) &&
              (ph == 1 || ph == 3 || (ph == 2 && c >= 6 && c <= 14));
      cycle();
      flick = 1'b0;
      n++;
    end
    chk("ign_len", n, 43);
    wait_idle();

    // Random flicks and mirror changes.
    for (int i = 0; i < 700; i++) begin
      flick = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) mirror = ~mirror;
      cycle();
    end
    flick = 1'b0;
    wait_idle();

    // Asynchronous reset in DN2, flick ignored under reset.
    start();
    wait_m0(4, 7);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_led0", {16'd0, led0}, 0);
    chk("arst_ph0", {29'd0, ph0}, 0);
    chk("arst_busy0", {31'd0, busy0}, 0);
    chk("arst_led1", {24'd0, led1}, 0);
    m_reset();
    flick = 1'b1;
    @(negedge CLK);
    compare_all();
    @(negedge CLK);
    compare_all();
    RST = 1'b0;
    cycle();
    flick = 1'b0;
    cycle();
    chk("rel_led", {16'd0, led0}, 32'h1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
